// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters (round-robin grant).
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority on simultaneous requests.
module alu_share_arbiter #(
    parameter int WIDTH        = 32,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [OPCODE_WIDTH-1:0] req_op0,
    input  logic [OPCODE_WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0]        req_a0,
    input  logic [WIDTH-1:0]        req_a1,
    input  logic [WIDTH-1:0]        req_b0,
    input  logic [WIDTH-1:0]        req_b1,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_flag,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [OPCODE_WIDTH-1:0] alu_op,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_flag,
    output logic [15:0]             op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    rr_ptr_q;
    logic                    gnt_id_q;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [WIDTH-1:0]        a_q;
    logic [WIDTH-1:0]        b_q;
    logic [WIDTH-1:0]        res_q;
    logic                    flag_q;
    logic [1:0]              rsp_valid_q;
    logic [15:0]             count_q;
    logic                    winner_d;

    // Winner is only meaningful while at least one request is valid.
    always_comb begin
        winner_d = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            winner_d = 1'b0;
`else
            winner_d = rr_ptr_q;
`endif
        end else begin
            winner_d = req_valid[1];
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && (|req_valid)) begin
            req_ready[winner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            gnt_id_q    <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            flag_q      <= 1'b0;
            rsp_valid_q <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        state_q  <= EXEC;
                        gnt_id_q <= winner_d;
                        op_q     <= winner_d ? req_op1 : req_op0;
                        a_q      <= winner_d ? req_a1 : req_a0;
                        b_q      <= winner_d ? req_b1 : req_b0;
                    end
                end
                EXEC: begin
                    res_q       <= alu_result;
                    flag_q      <= alu_flag;
                    rsp_valid_q <= gnt_id_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_id_q]) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= '0;
                        count_q     <= count_q + 16'd1;
                        rr_ptr_q    <= ~gnt_id_q;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= '0;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = res_q;
    assign rsp_flag   = flag_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a small behavioural ALU stands in for the shared unit.
module tb_alu_share_arbiter;

    localparam int W = 32;
    localparam int OW = 5;

    localparam logic [OW-1:0] OP_ADD = 5'b11010;
    localparam logic [OW-1:0] OP_SUB = 5'b11011;
    localparam logic [OW-1:0] OP_XOR = 5'b10100;
    localparam logic [OW-1:0] OP_LT  = 5'b00011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [OW-1:0] req_op0, req_op1;
    logic [W-1:0]  req_a0, req_a1, req_b0, req_b1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_flag;
    logic [W-1:0]  alu_a, alu_b;
    logic [OW-1:0] alu_op;
    logic [W-1:0]  alu_result;
    logic          alu_flag;
    logic [15:0]   op_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    alu_share_arbiter #(.WIDTH(W), .OPCODE_WIDTH(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        alu_flag   = 1'b0;
        case (alu_op)
            OP_ADD: alu_result = alu_a + alu_b;
            OP_SUB: alu_result = alu_a - alu_b;
            OP_XOR: alu_result = alu_a ^ alu_b;
            OP_LT: begin
                alu_flag   = $signed(alu_a) < $signed(alu_b);
                alu_result = {31'b0, alu_flag};
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_w;
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_flag", 32'(rsp_flag), 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD from requester 0
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 32'd1; req_b0 = 32'd1;
        rsp_ready = 2'b11;
        #1 chk("add_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("add_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("add_exec_req_ready", 32'(req_ready), 32'h0);
        chk("add_alu_a", alu_a, 32'h1);
        chk("add_alu_op", 32'(alu_op), 32'(OP_ADD));
        @(negedge clk);
        chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_rsp_result", rsp_result, 32'h2);
        chk("add_count_before", 32'(op_count), 32'h0);
        @(negedge clk);
        chk("add_rsp_done", 32'(rsp_valid), 32'h0);
        chk("add_count", 32'(op_count), 32'h1);

        // Signed compare from requester 1
        req_valid = 2'b10; req_op1 = OP_LT; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'h0;
        #1 chk("lt_req_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("lt_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("lt_rsp_flag", 32'(rsp_flag), 32'h1);
        @(negedge clk);
        chk("lt_count", 32'(op_count), 32'h2);

        // Round-robin with both requesters continuously valid
        req_valid = 2'b11;
        req_op0 = OP_SUB; req_a0 = 32'h0; req_b0 = 32'h1;
        req_op1 = OP_XOR; req_a1 = 32'hAAAA_AAAA; req_b1 = 32'h5555_5555;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_w = 1'b0;
`else
            exp_w = k[0];
`endif
            #1 chk("rr_req_ready", 32'(req_ready), exp_w ? 32'h2 : 32'h1);
            @(negedge clk);
            @(negedge clk);
            chk("rr_rsp_valid", 32'(rsp_valid), exp_w ? 32'h2 : 32'h1);
            chk("rr_rsp_result", rsp_result, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_count", 32'(op_count), 32'h6);

        // Backpressure: response held for 5 cycles, requester 1 waits
        rsp_ready = 2'b00;
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_result", rsp_result, 32'd12);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_count", 32'(op_count), 32'h6);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("bp_other_ready_ignored", 32'(rsp_valid), 32'h1);
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        chk("bp_release_count", 32'(op_count), 32'h7);
        chk("bp_waiter_ready", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("drop_no_capture", 32'(rsp_valid), 32'h0);
        chk("drop_count", 32'(op_count), 32'h7);

        // Reset mid-RESP
        rsp_ready = 2'b00;
        req_valid = 2'b10; req_op1 = OP_XOR; req_a1 = 32'h1; req_b1 = 32'h3;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h2);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_count", 32'(op_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_alu_op", 32'(alu_op), 32'h0);
        chk("post_rst_req_ready", 32'(req_ready), 32'h0);
        chk("post_rst_count", 32'(op_count), 32'h0);

        // Counter wrap
        dut.count_q = 16'hFFFF;
        #1 chk("wrap_preload", 32'(op_count), 32'hFFFF);
        rsp_ready = 2'b11;
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 32'h8000_0000; req_b0 = 32'h8000_0000;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("wrap_result", rsp_result, 32'h0);
        @(negedge clk);
        chk("wrap_count", 32'(op_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
